instr_fetch_ctrl: RTL and testbench

Instruction fetch sequencer placed between the program-order logic and the combinational instruction memory. It drives the memory address each cycle and captures the returned word into a small prefetch FIFO together with its PC. The FIFO feeds decode over a valid/ready handshake. It handles downstream stalls, branch/jump redirects (flush), and end-of-program detection.

---
 rtl/instr_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl
// Description : Fetch sequencer feeding a prefetch FIFO (pc + instruction)
//               to decode, with redirect flush and end-of-memory stop.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic [31:0]                imem_addr_o,
  input  logic [31:0]                imem_instr_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic [31:0]                instr_o,
  output logic [31:0]                pc_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       stopped_o
);

  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [32:0]     C_LIMIT = 33'(MEM_WORDS) * 33'd4;
  localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    STOP = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_target;
  logic          w_target_ok;
  logic [32:0]   w_pc_inc;
  logic          w_unused_lsbs;

  assign w_unused_lsbs = ^redirect_pc_i[1:0];
  assign w_target      = {redirect_pc_i[31:2], 2'b00};
  assign w_target_ok   = ({1'b0, w_target} < C_LIMIT);
  // 33-bit increment so the end-of-memory compare can never wrap
  assign w_pc_inc      = {1'b0, fetch_pc_q} + 33'd4;

  assign valid_o     = (count_q != '0) & ~redirect_i;
  assign w_pop       = valid_o & ready_i;
  assign w_push      = (state_q == RUN) & ((count_q < C_DEPTH) | w_pop) & ~redirect_i;

  assign imem_addr_o = fetch_pc_q;
  assign instr_o     = instr_q[rd_ptr_q];
  assign pc_o        = pc_q[rd_ptr_q];
  assign count_o     = count_q;
  assign stopped_o   = (state_q == STOP);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_i) begin
      fetch_pc_d = w_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      state_d    = w_target_ok ? RUN : STOP;
    end else begin
      if (w_push) begin
        fetch_pc_d = w_pc_inc[31:0];
        wr_ptr_d   = wr_ptr_q + PW'(1);
        if (w_pc_inc >= C_LIMIT) begin
          state_d = STOP;
        end
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (w_push) begin
        instr_q[wr_ptr_q] <= imem_instr_i;
        pc_q[wr_ptr_q]    <= fetch_pc_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_ctrl
// Description : Scoreboard bench for instr_fetch_ctrl; memory word[i] = i+100.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_instr;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic [31:0]   instr;
  logic [31:0]   pc;
  logic          valid;
  logic          ready = 1'b0;
  logic [CW-1:0] count;
  logic          stopped;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  instr_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0), .MEM_WORDS(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_addr_o  (imem_addr),
    .imem_instr_i (imem_instr),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .instr_o      (instr),
    .pc_o         (pc),
    .valid_o      (valid),
    .ready_i      (ready),
    .count_o      (count),
    .stopped_o    (stopped)
  );

  always #5 clk = ~clk;
  assign imem_instr = 32'd100 + (imem_addr >> 2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst      = 1'b0;
    redirect = 1'b0;
    ready    = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (valid !== 1'b0)   begin n_bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_cmp++; if (count !== '0)     begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (stopped !== 1'b0) begin n_bad++; $display("FAIL reset_stopped: got %b expected 0", stopped); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    n_cmp++; if (instr !== 32'h0 || pc !== 32'h0) begin
      n_bad++; $display("FAIL reset_head: got pc %h instr %h expected 0/0", pc, instr);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill();
    logic [CW-1:0] exp_cnt;
    apply_reset();
    for (int k = 0; k < 4; k++) sb_q.push_back('{pc: 32'(k * 4), instr: 32'(100 + k)});
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_cnt = (k > 4) ? CW'(4) : CW'(k);
      n_cmp++;
      if (count !== exp_cnt) begin n_bad++; $display("FAIL fill_count[%0d]: got %0d expected %0d", k, count, exp_cnt); end
    end
    n_cmp++; if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL fill_addr: got %h expected 10", imem_addr); end
    n_cmp++;
    if (valid !== 1'b1 || pc !== sb_q[0].pc || instr !== sb_q[0].instr) begin
      n_bad++; $display("FAIL fill_head: got v%b pc %h instr %0d expected v1 pc %h instr %0d", valid, pc, instr, sb_q[0].pc, sb_q[0].instr);
    end
  endtask

  task automatic test_full_pushpop();
    exp_t e;
    ready = 1'b1;
    sb_q.push_back('{pc: 32'h10, instr: 32'd104});
    #1;
    n_cmp++;
    if (valid && ready) begin
      e = sb_q.pop_front();
      if (pc !== e.pc || instr !== e.instr) begin
        n_bad++; $display("FAIL full_pop: got pc %h instr %0d expected pc %h instr %0d", pc, instr, e.pc, e.instr);
      end
    end else begin
      n_bad++; $display("FAIL full_pop: got no handshake expected handshake");
    end
    tick();
    ready = 1'b0;
    #1;
    n_cmp++; if (count !== CW'(4)) begin n_bad++; $display("FAIL full_count: got %0d expected 4", count); end
    n_cmp++; if (imem_addr !== 32'h14) begin n_bad++; $display("FAIL full_addr: got %h expected 14", imem_addr); end
    n_cmp++; if (pc !== sb_q[0].pc) begin n_bad++; $display("FAIL full_head: got pc %h expected %h", pc, sb_q[0].pc); end
  endtask

  task automatic test_streaming();
    exp_t e;
    int   pops;
    pops = 0;
    apply_reset();
    ready = 1'b1;
    for (int k = 0; k < 10; k++) sb_q.push_back('{pc: 32'(k * 4), instr: 32'(100 + k)});
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (count !== CW'(1)) begin n_bad++; $display("FAIL stream_count[%0d]: got %0d expected 1", c, count); end
      if (valid && ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        pops++;
        n_cmp++;
        if (pc !== e.pc || instr !== e.instr) begin
          n_bad++; $display("FAIL stream_data[%0d]: got pc %h instr %0d expected pc %h instr %0d", c, pc, instr, e.pc, e.instr);
        end
      end
    end
    n_cmp++; if (pops != 10) begin n_bad++; $display("FAIL stream_pops: got %0d expected 10", pops); end
  endtask

  task automatic test_redirect();
    exp_t e;
    redirect    = 1'b1;
    redirect_pc = 32'h42;
    sb_q.delete();
    sb_q.push_back('{pc: 32'h40, instr: 32'd116});
    sb_q.push_back('{pc: 32'h44, instr: 32'd117});
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid: got %b expected 0", valid); end
    tick();
    redirect = 1'b0;
    #1;
    n_cmp++;
    if (count !== '0 || valid !== 1'b0 || imem_addr !== 32'h40) begin
      n_bad++; $display("FAIL redir_flush: got cnt %0d v%b addr %h expected cnt 0 v0 addr 40", count, valid, imem_addr);
    end
    for (int c = 0; c < 2; c++) begin
      if (c > 0) tick(); else begin tick(); end
      n_cmp++;
      if (valid && ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (pc !== e.pc || instr !== e.instr || count !== CW'(1)) begin
          n_bad++; $display("FAIL redir_data[%0d]: got pc %h instr %0d cnt %0d expected pc %h instr %0d cnt 1", c, pc, instr, count, e.pc, e.instr);
        end
      end else begin
        n_bad++; $display("FAIL redir_data[%0d]: got valid %b expected 1", c, valid);
      end
    end
    // back-to-back redirects: only the second target survives
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect_pc = 32'h31;
    tick();
    redirect = 1'b0;
    n_cmp++; if (imem_addr !== 32'h30) begin n_bad++; $display("FAIL b2b_addr: got %h expected 30", imem_addr); end
    sb_q.delete();
    sb_q.push_back('{pc: 32'h30, instr: 32'd112});
    tick();
    n_cmp++;
    if (valid && ready && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (pc !== e.pc || instr !== e.instr) begin
        n_bad++; $display("FAIL b2b_data: got pc %h instr %0d expected pc %h instr %0d", pc, instr, e.pc, e.instr);
      end
    end else begin
      n_bad++; $display("FAIL b2b_data: got valid %b expected 1", valid);
    end
  endtask

  task automatic test_end_of_memory();
    exp_t e;
    redirect    = 1'b1;
    redirect_pc = 32'h78;
    sb_q.delete();
    sb_q.push_back('{pc: 32'h78, instr: 32'd130});
    sb_q.push_back('{pc: 32'h7C, instr: 32'd131});
    tick();
    redirect = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (valid && ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (pc !== e.pc || instr !== e.instr) begin
          n_bad++; $display("FAIL eom_data[%0d]: got pc %h instr %0d expected pc %h instr %0d", c, pc, instr, e.pc, e.instr);
        end
      end else begin
        n_bad++; $display("FAIL eom_data[%0d]: got valid %b expected 1", c, valid);
      end
      n_cmp++;
      if (stopped !== (c == 1)) begin n_bad++; $display("FAIL eom_stopped[%0d]: got %b expected %b", c, stopped, c == 1); end
    end
    tick();
    n_cmp++;
    if (valid !== 1'b0 || count !== '0 || stopped !== 1'b1 || imem_addr !== 32'h80) begin
      n_bad++; $display("FAIL eom_hold: got v%b cnt %0d stop %b addr %h expected v0 cnt 0 stop 1 addr 80", valid, count, stopped, imem_addr);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    tick();
    n_cmp++;
    if (stopped !== 1'b1 || count !== '0 || imem_addr !== 32'h80) begin
      n_bad++; $display("FAIL eom_oob_redir: got stop %b cnt %0d addr %h expected stop 1 cnt 0 addr 80", stopped, count, imem_addr);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    #1;
    n_cmp++;
    if (stopped !== 1'b0 || imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL eom_resume: got stop %b addr %h expected stop 0 addr 0", stopped, imem_addr);
    end
    sb_q.push_back('{pc: 32'h0, instr: 32'd100});
    tick();
    n_cmp++;
    if (valid && ready && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (pc !== e.pc || instr !== e.instr) begin
        n_bad++; $display("FAIL eom_resume_data: got pc %h instr %0d expected pc %h instr %0d", pc, instr, e.pc, e.instr);
      end
    end else begin
      n_bad++; $display("FAIL eom_resume_data: got valid %b expected 1", valid);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (3) tick();
    n_cmp++; if (count !== CW'(3)) begin n_bad++; $display("FAIL areset_pre: got cnt %0d expected 3", count); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || count !== '0 || stopped !== 1'b0 || imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL areset: got v%b cnt %0d stop %b addr %h expected v0 cnt 0 stop 0 addr 0", valid, count, stopped, imem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pushpop();
    test_streaming();
    test_redirect();
    test_end_of_memory();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
